// File: rtl/ltc2195_spi_responder.sv
// rtl/ltc2195_spi_responder.sv - LTC2195 serial port responder with register file.
// Define SPI_READBACK_EN to build the SDO read path; otherwise SDO/OE are tied low.
module ltc2195_spi_responder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] PD_RST      = 8'h00,
  parameter logic [7:0] TIMING_RST  = 8'h00,
  parameter logic [7:0] OUTMODE_RST = 8'h00,
  parameter logic [7:0] FORMAT_RST  = 8'h00
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        spi_scs_in,
  input  logic        spi_sck_in,
  input  logic        spi_sdi_in,
  output logic        spi_sdo_out,
  output logic        spi_sdo_oe_out,
  output logic [7:0]  cfg_pd_out,
  output logic [7:0]  cfg_timing_out,
  output logic [7:0]  cfg_outmode_out,
  output logic [7:0]  cfg_format_out,
  output logic [15:0] cfg_tp_out,
  output logic        wr_strobe_out,
  output logic [6:0]  wr_addr_out,
  output logic        busy_out
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] scs_sync, sck_sync, sdi_sync;
  logic                   cs_prev, sck_prev, armed;
  logic [2:0]             bit_cnt;
  logic [7:0]             cmd_sr;
  logic [6:0]             data_sr;

  logic cs_s, sck_s, sdi_s, sck_rise, sck_fall, cs_fall;
  logic [7:0] cmd_next, data_byte;

  assign cs_s      = scs_sync[SYNC_STAGES-1];
  assign sck_s     = sck_sync[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync[SYNC_STAGES-1];
  assign sck_rise  = sck_s & ~sck_prev;
  assign sck_fall  = ~sck_s & sck_prev;
  // CS sync resets low so a chip select held low across reset is never seen as a fall.
  assign cs_fall   = armed & cs_prev & ~cs_s;
  assign cmd_next  = {cmd_sr[6:0], sdi_s};
  assign data_byte = {data_sr, sdi_s};

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      scs_sync <= '0;
      sck_sync <= '0;
      sdi_sync <= '0;
      cs_prev  <= 1'b0;
      sck_prev <= 1'b0;
      armed    <= 1'b0;
    end else begin
      scs_sync <= {scs_sync[SYNC_STAGES-2:0], spi_scs_in};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_sck_in};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi_in};
      cs_prev  <= cs_s;
      sck_prev <= sck_s;
      armed    <= armed | cs_s;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state           <= IDLE;
      bit_cnt         <= 3'd0;
      cmd_sr          <= 8'h00;
      data_sr         <= 7'h00;
      cfg_pd_out      <= PD_RST;
      cfg_timing_out  <= TIMING_RST;
      cfg_outmode_out <= OUTMODE_RST;
      cfg_format_out  <= FORMAT_RST;
      cfg_tp_out      <= 16'h0000;
      wr_strobe_out   <= 1'b0;
      wr_addr_out     <= 7'h00;
      busy_out        <= 1'b0;
    end else begin
      wr_strobe_out <= 1'b0;
      busy_out      <= armed & ~cs_s;
      case (state)
        IDLE: begin
          bit_cnt <= 3'd0;
          if (cs_fall) state <= CMD;
        end
        CMD: begin
          if (cs_s) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
          end else if (sck_rise) begin
            cmd_sr  <= cmd_next;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= DATA;
          end
        end
        DATA: begin
          if (cs_s) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
          end else if (sck_rise) begin
            data_sr <= data_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= DONE;
              if (!cmd_sr[7]) begin
                case (cmd_sr[6:0])
                  7'h00: if (data_byte[7]) begin
                    cfg_pd_out      <= PD_RST;
                    cfg_timing_out  <= TIMING_RST;
                    cfg_outmode_out <= OUTMODE_RST;
                    cfg_format_out  <= FORMAT_RST;
                    cfg_tp_out      <= 16'h0000;
                    wr_strobe_out   <= 1'b1;
                    wr_addr_out     <= 7'h00;
                  end
                  7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h06: begin
                    case (cmd_sr[2:0])
                      3'd1:    cfg_pd_out        <= data_byte;
                      3'd2:    cfg_timing_out    <= data_byte;
                      3'd3:    cfg_outmode_out   <= data_byte;
                      3'd4:    cfg_format_out    <= data_byte;
                      3'd5:    cfg_tp_out[15:8]  <= data_byte;
                      default: cfg_tp_out[7:0]   <= data_byte;
                    endcase
                    wr_strobe_out <= 1'b1;
                    wr_addr_out   <= cmd_sr[6:0];
                  end
                  default: ;
                endcase
              end
            end
          end
        end
        DONE: begin
          if (cs_s) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_READBACK_EN
  logic [6:0] rd_sr;
  logic [7:0] rd_byte;

  always_comb begin
    rd_byte = 8'h00;
    case (cmd_next[6:0])
      7'h01:   rd_byte = cfg_pd_out;
      7'h02:   rd_byte = cfg_timing_out;
      7'h03:   rd_byte = cfg_outmode_out;
      7'h04:   rd_byte = cfg_format_out;
      7'h05:   rd_byte = cfg_tp_out[15:8];
      7'h06:   rd_byte = cfg_tp_out[7:0];
      default: rd_byte = 8'h00;
    endcase
  end

  // The shift refills with data[0] so SDO parks on the last bit after the eighth fall.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_sr          <= 7'h00;
      spi_sdo_out    <= 1'b0;
      spi_sdo_oe_out <= 1'b0;
    end else if (cs_s || state == IDLE || state == DONE) begin
      spi_sdo_oe_out <= 1'b0;
    end else if (state == CMD && sck_rise && bit_cnt == 3'd7 && cmd_next[7]) begin
      rd_sr          <= rd_byte[6:0];
      spi_sdo_out    <= rd_byte[7];
      spi_sdo_oe_out <= 1'b1;
    end else if (state == DATA && sck_rise && bit_cnt == 3'd7) begin
      spi_sdo_oe_out <= 1'b0;
    end else if (state == DATA && sck_fall && spi_sdo_oe_out) begin
      spi_sdo_out <= rd_sr[6];
      rd_sr       <= {rd_sr[5:0], rd_sr[0]};
    end
  end
`else
  assign spi_sdo_out    = 1'b0;
  assign spi_sdo_oe_out = 1'b0;
`endif

endmodule
